sdio_cmd_scheduler: RTL and testbench

SDIO_CMD_SCHEDULER -- requirements
Module: sdio_cmd_scheduler

---
 rtl/sdio_cmd_scheduler.sv | 225 ++++++++++++++++++++++
 tb/tb_sdio_cmd_scheduler.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sdio_cmd_scheduler.sv
// Round-robin scheduler sharing one SDIO command engine among three requesters.
// Define SDIO_CMD_TIMEOUT_EN to add the lost-command timeout in WAIT.
module sdio_cmd_scheduler #(
    parameter int TIMEOUT_CYCLES = 50000,
    parameter int GAP_CYCLES     = 16
) (
    input  logic        clk_100mhz,
    input  logic        reset_rtl_0,
    input  logic [2:0]  req_valid,
    input  logic [17:0] req_cmd,
    input  logic [95:0] req_arg,
    output logic [2:0]  req_ready,
    output logic [2:0]  rsp_valid,
    output logic [31:0] rsp_data,
    output logic        rsp_err,
    output logic        eng_start,
    output logic [5:0]  eng_cmd,
    output logic [31:0] eng_arg,
    input  logic        eng_busy,
    input  logic        eng_done,
    input  logic [31:0] eng_resp,
    input  logic        eng_crc_err
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ISSUE = 3'd1,
        WAIT  = 3'd2,
        RESP  = 3'd3,
        GAP   = 3'd4
    } state_t;

    localparam int               CNT_W    = 17;
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(GAP_CYCLES - 1);

    generate
        if (GAP_CYCLES < 1 || GAP_CYCLES > 131072 ||
            TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 131072) begin : g_bad_params
            $error("sdio_cmd_scheduler: GAP_CYCLES and TIMEOUT_CYCLES must be in 1..131072");
        end
    endgenerate

    state_t           r_state;
    state_t           w_state_nxt;
    logic [1:0]       r_last_grant;
    logic [1:0]       w_last_grant_nxt;
    logic [1:0]       w_winner;
    logic [2:0]       r_req_ready;
    logic [2:0]       w_req_ready_nxt;
    logic [2:0]       r_rsp_valid;
    logic [2:0]       w_rsp_valid_nxt;
    logic [31:0]      r_rsp_data;
    logic [31:0]      w_rsp_data_nxt;
    logic             r_rsp_err;
    logic             w_rsp_err_nxt;
    logic             r_eng_start;
    logic             w_eng_start_nxt;
    logic [5:0]       r_eng_cmd;
    logic [5:0]       w_eng_cmd_nxt;
    logic [31:0]      r_eng_arg;
    logic [31:0]      w_eng_arg_nxt;
    logic [CNT_W-1:0] r_gap_cnt;
    logic             w_timeout;

    // Search order starts just after the last winner; falls through to the last winner itself.
    function automatic logic [1:0] rr_pick(input logic [2:0] valid, input logic [1:0] last);
        logic [1:0] first;
        logic [1:0] second;
        logic [1:0] third;
        case (last)
            2'd0:    begin first = 2'd1; second = 2'd2; third = 2'd0; end
            2'd1:    begin first = 2'd2; second = 2'd0; third = 2'd1; end
            default: begin first = 2'd0; second = 2'd1; third = 2'd2; end
        endcase
        if (valid[first]) begin
            rr_pick = first;
        end else if (valid[second]) begin
            rr_pick = second;
        end else begin
            rr_pick = third;
        end
    endfunction

    function automatic logic [2:0] onehot3(input logic [1:0] idx);
        case (idx)
            2'd0:    onehot3 = 3'b001;
            2'd1:    onehot3 = 3'b010;
            default: onehot3 = 3'b100;
        endcase
    endfunction

    assign w_winner = rr_pick(req_valid, r_last_grant);

`ifdef SDIO_CMD_TIMEOUT_EN
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    logic [CNT_W-1:0] r_to_cnt;

    // Saturating lost-command counter, restarted on every entry to WAIT
    always_ff @(posedge clk_100mhz) begin
        if (!reset_rtl_0) begin
            r_to_cnt <= {CNT_W{1'b0}};
        end else if (r_state != WAIT) begin
            r_to_cnt <= {CNT_W{1'b0}};
        end else if (r_to_cnt != CNT_MAX) begin
            r_to_cnt <= r_to_cnt + 17'd1;
        end
    end

    assign w_timeout = (r_to_cnt == TO_LAST);
`else
    assign w_timeout = 1'b0;
`endif

    // Saturating inter-command gap counter, restarted on every entry to GAP
    always_ff @(posedge clk_100mhz) begin
        if (!reset_rtl_0) begin
            r_gap_cnt <= {CNT_W{1'b0}};
        end else if (r_state != GAP) begin
            r_gap_cnt <= {CNT_W{1'b0}};
        end else if (r_gap_cnt != CNT_MAX) begin
            r_gap_cnt <= r_gap_cnt + 17'd1;
        end
    end

    // Next state and next values of every registered output
    always_comb begin
        w_state_nxt      = r_state;
        w_last_grant_nxt = r_last_grant;
        w_req_ready_nxt  = 3'b000;
        w_rsp_valid_nxt  = 3'b000;
        w_rsp_data_nxt   = r_rsp_data;
        w_rsp_err_nxt    = r_rsp_err;
        w_eng_start_nxt  = 1'b0;
        w_eng_cmd_nxt    = r_eng_cmd;
        w_eng_arg_nxt    = r_eng_arg;
        case (r_state)
            IDLE: begin
                if (|req_valid) begin
                    w_last_grant_nxt = w_winner;
                    w_req_ready_nxt  = onehot3(w_winner);
                    w_state_nxt      = ISSUE;
                    case (w_winner)
                        2'd0:    begin w_eng_cmd_nxt = req_cmd[5:0];   w_eng_arg_nxt = req_arg[31:0];  end
                        2'd1:    begin w_eng_cmd_nxt = req_cmd[11:6];  w_eng_arg_nxt = req_arg[63:32]; end
                        default: begin w_eng_cmd_nxt = req_cmd[17:12]; w_eng_arg_nxt = req_arg[95:64]; end
                    endcase
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            ISSUE: begin
                if (!eng_busy) begin
                    w_eng_start_nxt = 1'b1;
                    w_state_nxt     = WAIT;
                end else begin
                    w_state_nxt = ISSUE;
                end
            end
            WAIT: begin
                // A completion in the expiry cycle still delivers the real response
                if (eng_done) begin
                    w_rsp_data_nxt  = eng_resp;
                    w_rsp_err_nxt   = eng_crc_err;
                    w_rsp_valid_nxt = onehot3(r_last_grant);
                    w_state_nxt     = RESP;
                end else if (w_timeout) begin
                    w_rsp_data_nxt  = 32'h0000_0000;
                    w_rsp_err_nxt   = 1'b1;
                    w_rsp_valid_nxt = onehot3(r_last_grant);
                    w_state_nxt     = RESP;
                end else begin
                    w_state_nxt = WAIT;
                end
            end
            RESP: begin
                w_state_nxt = GAP;
            end
            GAP: begin
                if (r_gap_cnt == GAP_LAST) begin
                    w_state_nxt = IDLE;
                end else begin
                    w_state_nxt = GAP;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // State register and output registers
    always_ff @(posedge clk_100mhz) begin
        if (!reset_rtl_0) begin
            r_state      <= IDLE;
            r_last_grant <= 2'd2;
            r_req_ready  <= 3'b000;
            r_rsp_valid  <= 3'b000;
            r_rsp_data   <= 32'h0000_0000;
            r_rsp_err    <= 1'b0;
            r_eng_start  <= 1'b0;
            r_eng_cmd    <= 6'd0;
            r_eng_arg    <= 32'h0000_0000;
        end else begin
            r_state      <= w_state_nxt;
            r_last_grant <= w_last_grant_nxt;
            r_req_ready  <= w_req_ready_nxt;
            r_rsp_valid  <= w_rsp_valid_nxt;
            r_rsp_data   <= w_rsp_data_nxt;
            r_rsp_err    <= w_rsp_err_nxt;
            r_eng_start  <= w_eng_start_nxt;
            r_eng_cmd    <= w_eng_cmd_nxt;
            r_eng_arg    <= w_eng_arg_nxt;
        end
    end

    assign req_ready = r_req_ready;
    assign rsp_valid = r_rsp_valid;
    assign rsp_data  = r_rsp_data;
    assign rsp_err   = r_rsp_err;
    assign eng_start = r_eng_start;
    assign eng_cmd   = r_eng_cmd;
    assign eng_arg   = r_eng_arg;

endmodule

// File: tb/tb_sdio_cmd_scheduler.sv
// Randomised self-checking bench for sdio_cmd_scheduler against a transaction-level model.
module tb_sdio_cmd_scheduler;

    localparam int GAP = 16;
    localparam int TO  = 100;

    logic        clk_100mhz = 1'b0;
    logic        reset_rtl_0;
    logic [2:0]  req_valid;
    logic [17:0] req_cmd;
    logic [95:0] req_arg;
    logic [2:0]  req_ready;
    logic [2:0]  rsp_valid;
    logic [31:0] rsp_data;
    logic        rsp_err;
    logic        eng_start;
    logic [5:0]  eng_cmd;
    logic [31:0] eng_arg;
    logic        eng_busy;
    logic        eng_done;
    logic [31:0] eng_resp;
    logic        eng_crc_err;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int model_last = 2;
    int prev_rsp_cyc = -1;
    int last_ready_cyc = 0;
    int last_start_cyc = 0;

    sdio_cmd_scheduler #(.TIMEOUT_CYCLES(TO), .GAP_CYCLES(GAP)) dut (
        .clk_100mhz (clk_100mhz),
        .reset_rtl_0(reset_rtl_0),
        .req_valid  (req_valid),
        .req_cmd    (req_cmd),
        .req_arg    (req_arg),
        .req_ready  (req_ready),
        .rsp_valid  (rsp_valid),
        .rsp_data   (rsp_data),
        .rsp_err    (rsp_err),
        .eng_start  (eng_start),
        .eng_cmd    (eng_cmd),
        .eng_arg    (eng_arg),
        .eng_busy   (eng_busy),
        .eng_done   (eng_done),
        .eng_resp   (eng_resp),
        .eng_crc_err(eng_crc_err)
    );

    always #5 clk_100mhz = ~clk_100mhz;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk_100mhz);
        #1;
        cyc++;
    endtask

    // Model: first requesting index after the previous winner, wrapping round to it.
    function automatic int rr_pick(input logic [2:0] mask, input int last);
        for (int k = 1; k <= 3; k++) begin
            if (mask[(last + k) % 3]) return (last + k) % 3;
        end
        return -1;
    endfunction

    task automatic set_req(input int i, input logic [5:0] c, input logic [31:0] a);
        req_valid[i]       = 1'b1;
        req_cmd[6*i +: 6]  = c;
        req_arg[32*i +: 32] = a;
    endtask

    // One full command: accept, issue (after busy_cycles), wait done_delay, response, gap start.
    task automatic run_one(input int busy_cycles, input int done_delay,
                           input logic [31:0] resp, input logic crc, output int granted);
        int          exp_w;
        int          exp_off;
        logic        exp_to;
        logic [5:0]  exp_cmd;
        logic [31:0] exp_arg;
        logic [2:0]  exp_rv;
        logic [31:0] exp_data;
        logic        exp_err;
        granted = -1;
        for (int t = 0; t < 200 && req_ready === 3'b000; t++) tick();
        checks++;
        if (req_ready === 3'b000) begin
            errors++;
            $display("FAIL accept_wait: req_ready=%b never asserted, req_valid=%b", req_ready, req_valid);
            return;
        end
        last_ready_cyc = cyc;
        for (int i = 0; i < 3; i++) if (req_ready[i] === 1'b1 && granted < 0) granted = i;
        exp_w   = rr_pick(req_valid, model_last);
        exp_cmd = req_cmd[6*exp_w +: 6];
        exp_arg = req_arg[32*exp_w +: 32];
        exp_rv  = 3'(1 << exp_w);
        checks++;
        if (req_ready !== exp_rv || eng_cmd !== exp_cmd || eng_arg !== exp_arg) begin
            errors++;
            $display("FAIL grant: ready=%b cmd=%0d arg=%h, expected ready=%b cmd=%0d arg=%h",
                     req_ready, eng_cmd, eng_arg, exp_rv, exp_cmd, exp_arg);
        end
        model_last       = exp_w;
        req_valid[exp_w] = 1'b0;
        eng_busy         = (busy_cycles > 0);
        for (int t = 1; t <= busy_cycles + 1; t++) begin
            tick();
            if (t == busy_cycles) eng_busy = 1'b0;
            checks++;
            if (eng_start !== (t == busy_cycles + 1)) begin
                errors++;
                $display("FAIL start_timing: eng_start=%b at cycle %0d after accept, expected %b",
                         eng_start, t, (t == busy_cycles + 1));
            end
        end
        last_start_cyc = cyc;
        if (prev_rsp_cyc >= 0) begin
            checks++;
            if (cyc - prev_rsp_cyc < GAP + 1 || cyc - prev_rsp_cyc > GAP + 3 + busy_cycles) begin
                errors++;
                $display("FAIL gap: %0d cycles from rsp_valid to eng_start, expected %0d..%0d",
                         cyc - prev_rsp_cyc, GAP + 1, GAP + 3 + busy_cycles);
            end
        end
        exp_to = 1'b0;
`ifdef SDIO_CMD_TIMEOUT_EN
        if (done_delay < 0 || done_delay >= TO) exp_to = 1'b1;
`endif
        exp_off  = exp_to ? TO : done_delay + 1;
        exp_data = exp_to ? 32'h0 : resp;
        exp_err  = exp_to ? 1'b1 : crc;
        for (int t = 0; t < exp_off; t++) begin
            eng_done    = (t == done_delay);
            eng_resp    = eng_done ? resp : $urandom();
            eng_crc_err = eng_done ? crc : 1'($urandom());
            tick();
            eng_done = 1'b0;
            checks++;
            if (t + 1 < exp_off) begin
                if (rsp_valid !== 3'b000 || eng_start !== 1'b0 || eng_cmd !== exp_cmd || eng_arg !== exp_arg) begin
                    errors++;
                    $display("FAIL wait_phase: rsp_valid=%b eng_start=%b cmd=%0d arg=%h, expected 000/0/%0d/%h",
                             rsp_valid, eng_start, eng_cmd, eng_arg, exp_cmd, exp_arg);
                end
            end else begin
                if (rsp_valid !== exp_rv || rsp_data !== exp_data || rsp_err !== exp_err) begin
                    errors++;
                    $display("FAIL response: rsp_valid=%b data=%h err=%b, expected %b/%h/%b",
                             rsp_valid, rsp_data, rsp_err, exp_rv, exp_data, exp_err);
                end
            end
        end
        prev_rsp_cyc = cyc;
        eng_done     = 1'b1;
        eng_resp     = $urandom();
        eng_crc_err  = 1'b1;
        for (int t = 0; t < 4; t++) begin
            tick();
            eng_done = 1'b0;
            checks++;
            if (rsp_valid !== 3'b000 || eng_start !== 1'b0 || req_ready !== 3'b000) begin
                errors++;
                $display("FAIL after_response: rsp_valid=%b eng_start=%b req_ready=%b, expected all 0",
                         rsp_valid, eng_start, req_ready);
            end
        end
    endtask

    task automatic test_reset();
        reset_rtl_0 = 1'b0;
        eng_busy = 1'b0; eng_done = 1'b0; eng_resp = 32'h0; eng_crc_err = 1'b0;
        req_valid = 3'b000; req_cmd = '0; req_arg = '0;
        for (int i = 0; i < 3; i++) set_req(i, 6'($urandom()), $urandom());
        for (int t = 0; t < 3; t++) begin
            tick();
            checks++;
            if (req_ready !== 3'b0 || rsp_valid !== 3'b0 || rsp_data !== 32'h0 || rsp_err !== 1'b0 ||
                eng_start !== 1'b0 || eng_cmd !== 6'd0 || eng_arg !== 32'h0) begin
                errors++;
                $display("FAIL reset_state: ready=%b rsp=%b data=%h err=%b start=%b cmd=%0d arg=%h, expected all 0",
                         req_ready, rsp_valid, rsp_data, rsp_err, eng_start, eng_cmd, eng_arg);
            end
        end
        reset_rtl_0 = 1'b1;
        model_last  = 2;
    endtask

    task automatic test_fairness();
        int order [4];
        int g;
        order = '{0, 1, 2, 0};
        for (int i = 0; i < 4; i++) begin
            run_one($urandom_range(0, 2), $urandom_range(0, 4), $urandom(), 1'($urandom()), g);
            checks++;
            if (g !== order[i]) begin
                errors++;
                $display("FAIL fairness: grant %0d went to %0d, expected %0d", i, g, order[i]);
            end
            if (i < 3 && g >= 0) set_req(g, 6'($urandom()), $urandom());
        end
        req_valid = 3'b000;
    endtask

    task automatic test_single();
        int g;
        int c0;
        for (int t = 0; t < 30; t++) tick();
        prev_rsp_cyc = -1;
        c0 = cyc;
        set_req(0, 6'd17, 32'h0000_0200);
        run_one(0, 2, 32'h0000_0900, 1'b0, g);
        checks++;
        if (g !== 0 || last_ready_cyc != c0 + 1 || last_start_cyc != c0 + 2) begin
            errors++;
            $display("FAIL single_latency: grant=%0d ready@+%0d start@+%0d, expected 0/+1/+2",
                     g, last_ready_cyc - c0, last_start_cyc - c0);
        end
    endtask

    task automatic test_busy();
        int g;
        set_req($urandom_range(0, 2), 6'($urandom()), $urandom());
        run_one(10, 1, $urandom(), 1'b1, g);
    endtask

    task automatic test_long_wait();
        int g;
`ifdef SDIO_CMD_TIMEOUT_EN
        set_req($urandom_range(0, 2), 6'($urandom()), $urandom());
        run_one(0, -1, $urandom(), 1'b0, g);
`endif
        set_req($urandom_range(0, 2), 6'($urandom()), $urandom());
        run_one(0, TO - 1, $urandom(), 1'b1, g);
        set_req($urandom_range(0, 2), 6'($urandom()), $urandom());
        run_one(0, 3 * TO, $urandom(), 1'b0, g);
    endtask

    task automatic test_reset_in_wait();
        int g;
        int c0;
        set_req(1, 6'($urandom()), $urandom());
        for (int t = 0; t < 200 && req_ready === 3'b000; t++) tick();
        checks++;
        if (req_ready !== 3'b010) begin
            errors++;
            $display("FAIL reset_wait_grant: req_ready=%b, expected 010", req_ready);
        end
        req_valid = 3'b000;
        eng_busy  = 1'b0;
        tick();
        tick();
        tick();
        reset_rtl_0 = 1'b0;
        tick();
        reset_rtl_0 = 1'b1;
        checks++;
        if (req_ready !== 3'b0 || rsp_valid !== 3'b0 || rsp_data !== 32'h0 || rsp_err !== 1'b0 ||
            eng_start !== 1'b0 || eng_cmd !== 6'd0 || eng_arg !== 32'h0) begin
            errors++;
            $display("FAIL reset_wait_outputs: ready=%b rsp=%b data=%h err=%b start=%b cmd=%0d arg=%h, expected all 0",
                     req_ready, rsp_valid, rsp_data, rsp_err, eng_start, eng_cmd, eng_arg);
        end
        model_last   = 2;
        prev_rsp_cyc = -1;
        eng_done     = 1'b1;
        eng_resp     = $urandom();
        tick();
        eng_done = 1'b0;
        for (int t = 0; t < 6; t++) begin
            checks++;
            if (rsp_valid !== 3'b000 || req_ready !== 3'b000 || eng_start !== 1'b0) begin
                errors++;
                $display("FAIL stray_done: rsp_valid=%b ready=%b start=%b, expected all 0",
                         rsp_valid, req_ready, eng_start);
            end
            tick();
        end
        c0 = cyc;
        for (int i = 0; i < 3; i++) set_req(i, 6'($urandom()), $urandom());
        run_one(0, 1, $urandom(), 1'b0, g);
        checks++;
        if (g !== 0 || last_ready_cyc != c0 + 1 || last_start_cyc != c0 + 2) begin
            errors++;
            $display("FAIL post_reset_grant: grant=%0d ready@+%0d start@+%0d, expected 0/+1/+2",
                     g, last_ready_cyc - c0, last_start_cyc - c0);
        end
        req_valid = 3'b000;
    endtask

    task automatic test_random();
        int g;
        for (int n = 0; n < 40; n++) begin
            for (int i = 0; i < 3; i++) begin
                if (req_valid[i] == 1'b0 && $urandom_range(0, 1) == 1) set_req(i, 6'($urandom()), $urandom());
            end
            if (req_valid == 3'b000) set_req($urandom_range(0, 2), 6'($urandom()), $urandom());
            run_one($urandom_range(0, 3), $urandom_range(0, 5), $urandom(), 1'($urandom()), g);
        end
        req_valid = 3'b000;
    endtask

    initial begin
        test_reset();
        test_fairness();
        test_single();
        test_busy();
        test_long_wait();
        test_reset_in_wait();
        test_random();
        for (int t = 0; t < 20; t++) tick();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
